// File: rtl/imem_if.sv
// Instruction memory bus between the fetch unit and instruction memory.
//   req    : read request, held with a stable addr until gnt
//   addr   : word-aligned request address
//   gnt    : request accepted this cycle
//   rvalid : read data valid, in order, at least one cycle after gnt
//   rdata  : 32-bit read data
// master = fetch unit, slave = memory.
interface imem_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one read at a time on the imem bus, buffers
// {pc, instruction} pairs in a small FIFO and hands them to decode through an
// output register advanced by phase_fetch. A jump flushes the buffer, turns
// any outstanding read into a stale one that is dropped, and restarts
// fetching at the word-aligned jump target.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   phase_fetch  : output register enable, consumes one buffered instruction
//   jump_valid   : redirect request, jump_addr is the target
//   imem         : instruction memory bus (master side)
//   inst         : instruction to decode (NOP after reset/flush)
//   curr_pc_fd   : PC of inst, next_pc_fd = curr_pc_fd + 4
//   inst_valid   : inst/PCs hold a real instruction
//   stall_fetch  : phase_fetch requested while the buffer is empty
module instruction_fetch #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              FIFO_DEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            phase_fetch,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_addr,
    imem_if.master          imem,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] curr_pc_fd,
    output logic [XLEN-1:0] next_pc_fd,
    output logic            inst_valid,
    output logic            stall_fetch
);
    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
    localparam logic [31:0]      NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;

    state_t           state_reg, state_next;
    logic [XLEN-1:0]  fetch_pc_reg, fetch_pc_next;
    // A redirect while a request is still waiting for gnt cannot withdraw
    // it (the address must stay stable), so FLUSH keeps presenting the old
    // address until it is granted and then drops its response.
    logic             stale_gnt_reg, stale_gnt_next;
    logic [XLEN-1:0]  stale_addr_reg, stale_addr_next;

    logic [XLEN-1:0]  buf_pc   [FIFO_DEPTH];
    logic [31:0]      buf_inst [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [31:0]      inst_reg;
    logic [XLEN-1:0]  curr_pc_reg, next_pc_reg;
    logic             valid_reg;

    logic buf_empty, accept_rsp, bypass, push, pop, has_space, space_after;

    // ------------------------------------------------------------------
    // Buffer control
    // ------------------------------------------------------------------
    assign buf_empty  = (count_reg == '0);
    // A response is only taken in WAIT; a same-cycle jump discards it.
    assign accept_rsp = (state_reg == WAIT) && imem.rvalid && !jump_valid;
    // Empty buffer and a consumer waiting: response goes straight out.
    assign bypass     = accept_rsp && phase_fetch && buf_empty;
    assign push       = accept_rsp && !bypass;
    assign pop        = phase_fetch && !jump_valid && !buf_empty;
    assign count_next = jump_valid ? '0
                      : count_reg + CNT_W'(push) - CNT_W'(pop);
    assign has_space   = (count_reg < DEPTH_C);
    assign space_after = (count_next < DEPTH_C);

    assign stall_fetch = phase_fetch && buf_empty;

    // ------------------------------------------------------------------
    // FSM next state and bus outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        fetch_pc_next   = fetch_pc_reg;
        stale_gnt_next  = stale_gnt_reg;
        stale_addr_next = stale_addr_reg;
        imem.req        = 1'b0;
        imem.addr       = fetch_pc_reg;

        if (jump_valid) begin
            fetch_pc_next = {jump_addr[XLEN-1:2], 2'b00};
        end else if (accept_rsp) begin
            fetch_pc_next = fetch_pc_reg + PC_STEP;
        end

        case (state_reg)
            IDLE: begin
                if (jump_valid) begin
                    state_next = REQ;
                end else if (has_space && !rst) begin
                    // Request straight out of IDLE so the first read is
                    // visible in the very first cycle after reset.
                    imem.req   = 1'b1;
                    state_next = imem.gnt ? WAIT : REQ;
                end
            end
            REQ: begin
                imem.req = 1'b1;
                if (jump_valid) begin
                    state_next      = FLUSH;
                    stale_gnt_next  = !imem.gnt;
                    stale_addr_next = fetch_pc_reg;
                end else if (imem.gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem.rvalid) begin
                    state_next = space_after ? REQ : IDLE;
                end else if (jump_valid) begin
                    state_next     = FLUSH;
                    stale_gnt_next = 1'b0;
                end
            end
            FLUSH: begin
                if (stale_gnt_reg) begin
                    imem.req  = 1'b1;
                    imem.addr = stale_addr_reg;
                    if (imem.gnt) begin
                        stale_gnt_next = 1'b0;
                    end
                end else if (imem.rvalid) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            fetch_pc_reg   <= RESET_VECTOR;
            stale_gnt_reg  <= 1'b0;
            stale_addr_reg <= RESET_VECTOR;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            fetch_pc_reg   <= fetch_pc_next;
            stale_gnt_reg  <= stale_gnt_next;
            stale_addr_reg <= stale_addr_next;
            count_reg      <= count_next;
            if (jump_valid) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // Buffer storage: plain array, no reset, read through the output register.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr_reg]   <= fetch_pc_reg;
            buf_inst[wr_ptr_reg] <= imem.rdata;
        end
    end

    // ------------------------------------------------------------------
    // Output register to decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_reg    <= NOP;
            curr_pc_reg <= RESET_VECTOR;
            next_pc_reg <= RESET_VECTOR;
            valid_reg   <= 1'b0;
        end else if (jump_valid) begin
            inst_reg  <= NOP;
            valid_reg <= 1'b0;
        end else if (pop) begin
            inst_reg    <= buf_inst[rd_ptr_reg];
            curr_pc_reg <= buf_pc[rd_ptr_reg];
            next_pc_reg <= buf_pc[rd_ptr_reg] + PC_STEP;
            valid_reg   <= 1'b1;
        end else if (bypass) begin
            inst_reg    <= imem.rdata;
            curr_pc_reg <= fetch_pc_reg;
            next_pc_reg <= fetch_pc_reg + PC_STEP;
            valid_reg   <= 1'b1;
        end else if (phase_fetch) begin
            valid_reg <= 1'b0;
        end
    end

    assign inst       = inst_reg;
    assign curr_pc_fd = curr_pc_reg;
    assign next_pc_fd = next_pc_reg;
    assign inst_valid = valid_reg;
endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        phase_fetch;
    logic        jump_valid;
    logic [31:0] jump_addr;
    logic [31:0] inst;
    logic [31:0] curr_pc_fd;
    logic [31:0] next_pc_fd;
    logic        inst_valid;
    logic        stall_fetch;

    int checks   = 0;
    int failures = 0;

    imem_if #(.XLEN(32)) imem_bus ();

    instruction_fetch #(
        .XLEN(32),
        .RESET_VECTOR(32'h0),
        .FIFO_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .phase_fetch(phase_fetch),
        .jump_valid(jump_valid),
        .jump_addr(jump_addr),
        .imem(imem_bus),
        .inst(inst),
        .curr_pc_fd(curr_pc_fd),
        .next_pc_fd(next_pc_fd),
        .inst_valid(inst_valid),
        .stall_fetch(stall_fetch)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs sampled 2 time
    // units after the rising edge.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic grant_cycle;
        imem_bus.gnt = 1'b1;
        tick();
        imem_bus.gnt = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        imem_bus.rvalid = 1'b1;
        imem_bus.rdata  = data;
        tick();
        imem_bus.rvalid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; phase_fetch = 1'b0; jump_valid = 1'b0; jump_addr = '0;
        imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = '0;
        tick(); tick();
        checks++; if (imem_bus.req !== 1'b0) begin failures++; $display("FAIL rst_req: got %0b expected 0", imem_bus.req); end
        checks++; if (imem_bus.addr !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h expected 00000000", imem_bus.addr); end
        checks++; if (inst !== 32'h13) begin failures++; $display("FAIL rst_inst: got %h expected 00000013", inst); end
        checks++; if (curr_pc_fd !== 32'h0 || next_pc_fd !== 32'h0) begin failures++; $display("FAIL rst_pcs: got %h/%h expected 0/0", curr_pc_fd, next_pc_fd); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b expected 0", inst_valid); end
        rst = 1'b0;
        #1;
        checks++; if (imem_bus.req !== 1'b1) begin failures++; $display("FAIL first_req: got %0b expected 1", imem_bus.req); end
        $display("test_reset: reset values and first request checked");
    endtask

    task automatic test_first_fetch;
        grant_cycle();
        checks++; if (imem_bus.req !== 1'b0) begin failures++; $display("FAIL wait_req: got %0b expected 0", imem_bus.req); end
        respond(32'h0050_0093);
        checks++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h4) begin failures++; $display("FAIL v1_next_addr: got req=%0b addr=%h expected 1/00000004", imem_bus.req, imem_bus.addr); end
        phase_fetch = 1'b1;
        tick();
        phase_fetch = 1'b0;
        checks++; if (inst !== 32'h0050_0093 || curr_pc_fd !== 32'h0 || next_pc_fd !== 32'h4) begin failures++; $display("FAIL v1_pop: got %h pc=%h npc=%h expected 00500093/0/4", inst, curr_pc_fd, next_pc_fd); end
        checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL v1_valid: got %0b expected 1", inst_valid); end
        checks++; if (imem_bus.addr !== 32'h4) begin failures++; $display("FAIL v1_addr_hold: got %h expected 00000004", imem_bus.addr); end
        $display("test_first_fetch: fetch at 0x0 delivered");
    endtask

    task automatic test_fill_buffer;
        grant_cycle(); respond(32'hA1A1_A1A1);
        grant_cycle(); respond(32'hA2A2_A2A2);
        checks++; if (imem_bus.req !== 1'b0) begin failures++; $display("FAIL v2_full_req: got %0b expected 0", imem_bus.req); end
        tick(); tick();
        checks++; if (imem_bus.req !== 1'b0) begin failures++; $display("FAIL v2_full_hold: got %0b expected 0", imem_bus.req); end
        phase_fetch = 1'b1;
        tick();
        phase_fetch = 1'b0;
        checks++; if (inst !== 32'hA1A1_A1A1 || curr_pc_fd !== 32'h4 || next_pc_fd !== 32'h8) begin failures++; $display("FAIL v2_pop: got %h pc=%h npc=%h expected a1a1a1a1/4/8", inst, curr_pc_fd, next_pc_fd); end
        checks++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'hC) begin failures++; $display("FAIL v2_resume: got req=%0b addr=%h expected 1/0000000c", imem_bus.req, imem_bus.addr); end
        $display("test_fill_buffer: buffer filled to depth and resumed");
    endtask

    task automatic test_jump_in_wait;
        grant_cycle();
        jump_valid = 1'b1; jump_addr = 32'h103;
        tick();
        jump_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || inst !== 32'h13) begin failures++; $display("FAIL v3_flush_out: got valid=%0b inst=%h expected 0/00000013", inst_valid, inst); end
        checks++; if (imem_bus.req !== 1'b0) begin failures++; $display("FAIL v3_flush_req: got %0b expected 0", imem_bus.req); end
        respond(32'hDEAD_BEEF);
        checks++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h100) begin failures++; $display("FAIL v3_target: got req=%0b addr=%h expected 1/00000100", imem_bus.req, imem_bus.addr); end
        grant_cycle(); respond(32'h1111_1111);
        phase_fetch = 1'b1;
        #1;
        checks++; if (stall_fetch !== 1'b0) begin failures++; $display("FAIL v3_no_stall: got %0b expected 0", stall_fetch); end
        tick();
        checks++; if (inst !== 32'h1111_1111 || curr_pc_fd !== 32'h100 || next_pc_fd !== 32'h104) begin failures++; $display("FAIL v3_pop: got %h pc=%h npc=%h expected 11111111/100/104", inst, curr_pc_fd, next_pc_fd); end
        $display("test_jump_in_wait: stale response dropped");
    endtask

    task automatic test_empty_stall;
        // phase_fetch still high, buffer now empty, no response
        checks++; if (stall_fetch !== 1'b1) begin failures++; $display("FAIL v5_stall: got %0b expected 1", stall_fetch); end
        tick();
        phase_fetch = 1'b0;
        checks++; if (inst !== 32'h1111_1111 || curr_pc_fd !== 32'h100 || next_pc_fd !== 32'h104) begin failures++; $display("FAIL v5_hold: got %h pc=%h npc=%h expected 11111111/100/104", inst, curr_pc_fd, next_pc_fd); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL v5_valid: got %0b expected 0", inst_valid); end
        $display("test_empty_stall: stall with held outputs");
    endtask

    task automatic test_jump_with_pop;
        grant_cycle(); respond(32'h2222_2222);
        grant_cycle(); respond(32'h3333_3333);
        checks++; if (imem_bus.req !== 1'b0) begin failures++; $display("FAIL v4_full: got %0b expected 0", imem_bus.req); end
        jump_valid = 1'b1; jump_addr = 32'h200; phase_fetch = 1'b1;
        tick();
        jump_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0 || inst !== 32'h13) begin failures++; $display("FAIL v4_out: got valid=%0b inst=%h expected 0/00000013", inst_valid, inst); end
        checks++; if (stall_fetch !== 1'b1) begin failures++; $display("FAIL v4_empty: got %0b expected 1", stall_fetch); end
        phase_fetch = 1'b0;
        checks++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h200) begin failures++; $display("FAIL v4_target: got req=%0b addr=%h expected 1/00000200", imem_bus.req, imem_bus.addr); end
        $display("test_jump_with_pop: jump wins over pop");
    endtask

    task automatic test_bypass;
        grant_cycle();
        phase_fetch = 1'b1;
        respond(32'h4444_4444);
        phase_fetch = 1'b0;
        checks++; if (inst !== 32'h4444_4444 || curr_pc_fd !== 32'h200 || next_pc_fd !== 32'h204 || inst_valid !== 1'b1) begin failures++; $display("FAIL bypass_out: got %h pc=%h npc=%h v=%0b expected 44444444/200/204/1", inst, curr_pc_fd, next_pc_fd, inst_valid); end
        checks++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h204) begin failures++; $display("FAIL bypass_next: got req=%0b addr=%h expected 1/00000204", imem_bus.req, imem_bus.addr); end
        phase_fetch = 1'b1;
        #1;
        checks++; if (stall_fetch !== 1'b1) begin failures++; $display("FAIL bypass_empty: got %0b expected 1", stall_fetch); end
        phase_fetch = 1'b0;
        $display("test_bypass: response loaded directly to outputs");
    endtask

    task automatic test_jump_in_req;
        jump_valid = 1'b1; jump_addr = 32'h300;
        tick();
        jump_valid = 1'b0;
        checks++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h204) begin failures++; $display("FAIL req_stale_hold: got req=%0b addr=%h expected 1/00000204", imem_bus.req, imem_bus.addr); end
        grant_cycle();
        checks++; if (imem_bus.req !== 1'b0) begin failures++; $display("FAIL req_stale_wait: got %0b expected 0", imem_bus.req); end
        respond(32'h5555_5555);
        checks++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h300) begin failures++; $display("FAIL req_target: got req=%0b addr=%h expected 1/00000300", imem_bus.req, imem_bus.addr); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL req_valid: got %0b expected 0", inst_valid); end
        $display("test_jump_in_req: ungranted request flushed");
    endtask

    task automatic test_wrap;
        grant_cycle();
        jump_valid = 1'b1; jump_addr = 32'hFFFF_FFFE;
        respond(32'h6666_6666);
        jump_valid = 1'b0;
        checks++; if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL v6_target: got req=%0b addr=%h expected 1/fffffffc", imem_bus.req, imem_bus.addr); end
        grant_cycle(); respond(32'h7777_7777);
        checks++; if (imem_bus.addr !== 32'h0) begin failures++; $display("FAIL v6_addr_wrap: got %h expected 00000000", imem_bus.addr); end
        phase_fetch = 1'b1;
        tick();
        phase_fetch = 1'b0;
        checks++; if (inst !== 32'h7777_7777 || curr_pc_fd !== 32'hFFFF_FFFC || next_pc_fd !== 32'h0) begin failures++; $display("FAIL v6_pop: got %h pc=%h npc=%h expected 77777777/fffffffc/0", inst, curr_pc_fd, next_pc_fd); end
        $display("test_wrap: PC wraps at top of address space");
    endtask

    task automatic test_reset_mid;
        grant_cycle();
        rst = 1'b1;
        #1;
        checks++; if (imem_bus.req !== 1'b0 || imem_bus.addr !== 32'h0) begin failures++; $display("FAIL mid_rst_bus: got req=%0b addr=%h expected 0/0", imem_bus.req, imem_bus.addr); end
        checks++; if (inst !== 32'h13 || inst_valid !== 1'b0 || curr_pc_fd !== 32'h0) begin failures++; $display("FAIL mid_rst_out: got %h v=%0b pc=%h expected 13/0/0", inst, inst_valid, curr_pc_fd); end
        tick();
        rst = 1'b0;
        respond(32'h9999_9999);
        phase_fetch = 1'b1;
        tick();
        phase_fetch = 1'b0;
        checks++; if (inst !== 32'h13 || inst_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_drop: got %h v=%0b expected 00000013/0", inst, inst_valid); end
        $display("test_reset_mid: pending response dropped");
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_fill_buffer();
        test_jump_in_wait();
        test_empty_stall();
        test_jump_with_pop();
        test_bypass();
        test_jump_in_req();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
